rand_share_arbiter: RTL and testbench
=====================================

Name: rand_share_arbiter

Overview:
Shares one free-running random-word source among NREQ stimulus requesters in the AHB VIP. Requesters ask for a burst of random words; the block arbitrates round-robin, grants ownership, and delivers one fresh source sample per accepted beat. It also watches the source for lock-up (repeated or stuck values) and blocks new grants on error.

Parameters:
NREQ, 4, number of requesters (2..8)
IDW, 2, width of requester id; must equal ceil(log2(NREQ))
WIDTH, 4, random word width; matches the source output
STUCK_LIM, 8, consecutive identical source samples that flag src_err (>=2)

Ports:
clk  input  1  system clock; all state updates on posedge
reset  input  1  asynchronous, active-high reset
rnd_in  input  WIDTH  random word from the source; updates on negedge clk, sampled on posedge
req  input  NREQ  per-requester burst request, level; held until the burst ends
len  input  NREQ*4  per-requester burst length minus 1 (slice i = len[4i+3:4i]); 1..16 words
rdy  input  NREQ  per-requester beat accept; a beat issues only when the owner's rdy is high
gnt  output  NREQ  one-hot ownership, high while owner's burst is active
rnd_valid  output  1  beat valid, one-cycle pulse per word
rnd_data  output  WIDTH  delivered random word
rnd_id  output  IDW  owner id qualifying rnd_data
rnd_last  output  1  high with final beat of a burst
aborted  output  1  one-cycle pulse when a burst is truncated by req withdrawal
src_err  output  1  sticky source lock-up flag

Behaviour:
- Reset (async, any time incl. mid-burst): state IDLE; gnt=0, rnd_valid=0, rnd_data=0, rnd_id=0, rnd_last=0, aborted=0, src_err=0, stuck count=0, previous sample=0, rr pointer = NREQ-1 (req0 has first priority). Any burst in progress is discarded with no further beats.
- All outputs are registered.
- FSM IDLE:
  - If src_err=0 and any req bit set, pick the first set bit searching from (rr+1) mod NREQ upward with wrap.
  - Latch id and count = len[id]+1 (5-bit); set rr=id; go to BURST; gnt[id]=1 from the next cycle.
  - No request, or src_err=1: stay IDLE.
- FSM BURST, per posedge, checked in this priority:
  1. req[id]=0: go to IDLE, gnt=0, aborted=1 for one cycle, no beat.
  2. rdy[id]=1: issue a beat:
     - rnd_valid=1, rnd_data=rnd_in sampled at this edge, rnd_id=id, rnd_last=(count==1), count decremented.
     - If count was 1: go to IDLE and clear gnt at the same edge, so gnt is already low in the rnd_last cycle.
  3. rdy[id]=0: no beat; rnd_valid=0; count held. The stalled word is not buffered; the next accepted beat takes the current sample.
- rnd_valid, rnd_last and aborted are 0 in every cycle without the corresponding event.
- rnd_data and rnd_id hold their last value when rnd_valid=0.
- Grant timing:
  - A request needs one IDLE arbitration edge, so the first beat arrives at the earliest 2 edges after req rises.
  - There is one IDLE cycle between back-to-back bursts.
  - Requests from other requesters during BURST are ignored until IDLE.
- Fairness: after a burst by id k, priority starts at k+1 mod NREQ; a continuously requesting set is served in strict rotation.
- Source monitor (runs in every state):
  - Each edge compares rnd_in with the previous sample. Equal: stuck count increments (saturating at STUCK_LIM). Different: count clears.
  - When the count reaches STUCK_LIM-1 repeats (STUCK_LIM identical samples), src_err sets and stays set until reset.
  - An all-zero source (LFSR lock-up) is caught by the same rule.
  - src_err does not truncate an active burst; it only blocks new grants.
- len=4'hF gives 16 beats; len is sampled only at grant, so later changes have no effect on the active burst.

Test Plan:
- req=0001, len0=2, rdy=1111 -> gnt=0001 from edge 1; three rnd_valid pulses on consecutive cycles with rnd_id=0 and rnd_data = source sample at each edge; rnd_last on the 3rd; gnt low in that cycle; req1..3 never granted.
- req=1111 held, all len=0, rdy=1111 -> grant order 0,1,2,3,0,... with one IDLE cycle between bursts; each burst has exactly one beat with rnd_last=1.
- Owner 2, len=3, rdy[2] low for 2 cycles mid-burst -> still exactly 4 beats, no valid during the stall, data equals the source at each accepted edge.
- Owner 1 drops req after 2 of 5 beats -> aborted pulses once, gnt=0, no further beats, rnd_last never asserted; next arbitration starts priority at id 2.
- rnd_in forced to 4'h0 for 8 edges -> src_err=1 on the 8th sample; a pending req is not granted; src_err stays set after rnd_in resumes; reset clears it.
- Assert reset during beat 2 of a 4-beat burst -> all outputs 0 immediately; after release, req0 is granted first if asserted.

Source files
------------

// File: rtl/rand_share_arbiter.sv
// rtl/rand_share_arbiter.sv - round-robin burst arbiter sharing one random-word source with lock-up monitor
module rand_share_arbiter #(
    parameter int NREQ      = 4,
    parameter int IDW       = 2,
    parameter int WIDTH     = 4,
    parameter int STUCK_LIM = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [WIDTH-1:0]   rnd_in,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*4-1:0]  len,
    input  logic [NREQ-1:0]    rdy,
    output logic [NREQ-1:0]    gnt,
    output logic               rnd_valid,
    output logic [WIDTH-1:0]   rnd_data,
    output logic [IDW-1:0]     rnd_id,
    output logic               rnd_last,
    output logic               aborted,
    output logic               src_err
);

    localparam int SCW = $clog2(STUCK_LIM + 1);

    typedef enum logic {IDLE, BURST} state_t;

    state_t           state_q, state_d;
    logic [IDW-1:0]   id_q, id_d;
    logic [IDW-1:0]   rr_q, rr_d;
    logic [4:0]       cnt_q, cnt_d;
    logic [NREQ-1:0]  gnt_d;
    logic             valid_d, last_d, abort_d, err_d;
    logic [WIDTH-1:0] data_d;
    logic [IDW-1:0]   rid_d;
    logic [WIDTH-1:0] prev_q;
    logic [SCW-1:0]   stuck_q, stuck_d;

    logic             found;
    logic [IDW-1:0]   pick;

    // Round-robin search starting one past the last served requester
    always_comb begin
        found = 1'b0;
        pick  = '0;
        for (int k = 1; k <= NREQ; k++) begin
            int idx;
            idx = (int'(rr_q) + k) % NREQ;
            if (!found && req[idx]) begin
                found = 1'b1;
                pick  = IDW'(idx);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        rr_d    = rr_q;
        cnt_d   = cnt_q;
        gnt_d   = gnt;
        valid_d = 1'b0;
        last_d  = 1'b0;
        abort_d = 1'b0;
        data_d  = rnd_data;
        rid_d   = rnd_id;
        case (state_q)
            IDLE: begin
                if (!src_err && found) begin
                    id_d    = pick;
                    rr_d    = pick;
                    cnt_d   = {1'b0, len[int'(pick)*4 +: 4]} + 5'd1;
                    gnt_d   = NREQ'(1) << pick;
                    state_d = BURST;
                end
            end
            BURST: begin
                if (!req[id_q]) begin
                    state_d = IDLE;
                    gnt_d   = '0;
                    abort_d = 1'b1;
                end else if (rdy[id_q]) begin
                    valid_d = 1'b1;
                    data_d  = rnd_in;
                    rid_d   = id_q;
                    last_d  = (cnt_q == 5'd1);
                    cnt_d   = cnt_q - 5'd1;
                    // Drop grant on the final beat so it is already low with rnd_last
                    if (cnt_q == 5'd1) begin
                        state_d = IDLE;
                        gnt_d   = '0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Lock-up monitor: STUCK_LIM identical consecutive samples latch src_err
    always_comb begin
        stuck_d = '0;
        if (rnd_in == prev_q) begin
            stuck_d = (stuck_q == SCW'(STUCK_LIM)) ? stuck_q : stuck_q + SCW'(1);
        end
        err_d = src_err | (stuck_d >= SCW'(STUCK_LIM - 1));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            id_q      <= '0;
            rr_q      <= IDW'(NREQ - 1);
            cnt_q     <= '0;
            gnt       <= '0;
            rnd_valid <= 1'b0;
            rnd_data  <= '0;
            rnd_id    <= '0;
            rnd_last  <= 1'b0;
            aborted   <= 1'b0;
            src_err   <= 1'b0;
            prev_q    <= '0;
            stuck_q   <= '0;
        end else begin
            state_q   <= state_d;
            id_q      <= id_d;
            rr_q      <= rr_d;
            cnt_q     <= cnt_d;
            gnt       <= gnt_d;
            rnd_valid <= valid_d;
            rnd_data  <= data_d;
            rnd_id    <= rid_d;
            rnd_last  <= last_d;
            aborted   <= abort_d;
            src_err   <= err_d;
            prev_q    <= rnd_in;
            stuck_q   <= stuck_d;
        end
    end

endmodule

// File: tb/tb_rand_share_arbiter.sv
// tb/tb_rand_share_arbiter.sv - directed self-checking bench for rand_share_arbiter
module tb_rand_share_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  rnd_in;
    logic [3:0]  req;
    logic [15:0] len;
    logic [3:0]  rdy;
    logic [3:0]  gnt;
    logic        rnd_valid;
    logic [3:0]  rnd_data;
    logic [1:0]  rnd_id;
    logic        rnd_last;
    logic        aborted;
    logic        src_err;

    int errors = 0;
    int checks = 0;
    logic [3:0] src_q = 4'h3;

    rand_share_arbiter #(.NREQ(4), .IDW(2), .WIDTH(4), .STUCK_LIM(8)) dut (
        .clk(clk), .reset(reset), .rnd_in(rnd_in), .req(req), .len(len), .rdy(rdy),
        .gnt(gnt), .rnd_valid(rnd_valid), .rnd_data(rnd_data), .rnd_id(rnd_id),
        .rnd_last(rnd_last), .aborted(aborted), .src_err(src_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input logic [3:0] r);
        @(negedge clk);
        rnd_in = r;
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        src_q = src_q + 4'd5;
        cyc(src_q);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cyc(4'h1);
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; rnd_in = '0; req = '0; len = '0; rdy = '0;
        tick();
        tick();
        reset = 1'b0;
        check("rst_gnt", gnt, 0);
        check("rst_valid", rnd_valid, 0);
        check("rst_data", rnd_data, 0);
        check("rst_err", src_err, 0);

        // Single requester, 3-beat burst
        req = 4'b0001; len = 16'hFFF2; rdy = 4'hF;
        tick();
        check("t1_gnt", gnt, 4'b0001);
        check("t1_novalid", rnd_valid, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t1_valid", rnd_valid, 1);
            check("t1_data", rnd_data, rnd_in);
            check("t1_id", rnd_id, 0);
            check("t1_last", rnd_last, (i == 2) ? 1 : 0);
            check("t1_gnt_b", gnt, (i == 2) ? 4'b0000 : 4'b0001);
        end
        req = 4'b0000;
        tick();
        check("t1_idle_valid", rnd_valid, 0);
        check("t1_idle_gnt", gnt, 0);

        // All requesting, single-beat bursts rotate 0,1,2,3,0
        do_reset();
        req = 4'hF; len = 16'h0000; rdy = 4'hF;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("t2_gnt", gnt, 32'(1) << (k % 4));
            check("t2_novalid", rnd_valid, 0);
            tick();
            check("t2_valid", rnd_valid, 1);
            check("t2_id", rnd_id, k % 4);
            check("t2_last", rnd_last, 1);
            check("t2_gnt_off", gnt, 0);
            check("t2_data", rnd_data, rnd_in);
        end
        req = 4'h0;
        tick();

        // Owner 2, 4 beats, two stall cycles
        req = 4'b0100; len = 16'h0300;
        tick();
        check("t3_gnt", gnt, 4'b0100);
        begin
            logic [5:0] stall_tab;
            stall_tab = 6'b111001;
            for (int i = 0; i < 6; i++) begin
                rdy = stall_tab[i] ? 4'hF : 4'hB;
                tick();
                check("t3_valid", rnd_valid, stall_tab[i]);
                if (stall_tab[i]) check("t3_data", rnd_data, rnd_in);
                check("t3_last", rnd_last, (i == 5) ? 1 : 0);
                check("t3_gnt_b", gnt, (i == 5) ? 4'b0000 : 4'b0100);
            end
        end
        req = 4'h0; rdy = 4'hF;
        tick();

        // Owner 1 withdraws after 2 of 5 beats; next priority starts at 2
        req = 4'b0010; len = 16'h0040;
        tick();
        check("t4_gnt", gnt, 4'b0010);
        for (int i = 0; i < 2; i++) begin
            tick();
            check("t4_valid", rnd_valid, 1);
            check("t4_id", rnd_id, 1);
            check("t4_last", rnd_last, 0);
        end
        req = 4'b1101;
        tick();
        check("t4_abort", aborted, 1);
        check("t4_abort_gnt", gnt, 0);
        check("t4_abort_valid", rnd_valid, 0);
        check("t4_abort_last", rnd_last, 0);
        tick();
        check("t4_next_gnt", gnt, 4'b0100);
        check("t4_abort_pulse", aborted, 0);
        check("t4_novalid", rnd_valid, 0);
        req = 4'b0000;
        tick();
        check("t4_abort2", aborted, 1);
        tick();
        check("t4_abort2_end", aborted, 0);

        // All-zero source latches src_err on the 8th identical sample
        cyc(4'h9);
        for (int i = 1; i <= 8; i++) begin
            cyc(4'h0);
            if (i == 7) check("t5_err_pre", src_err, 0);
            if (i == 8) check("t5_err_set", src_err, 1);
        end
        req = 4'b0001; len = 16'h0000;
        cyc(4'h5);
        check("t5_nogrant_a", gnt, 0);
        cyc(4'h6);
        check("t5_nogrant_b", gnt, 0);
        check("t5_sticky", src_err, 1);
        req = 4'b0000;
        do_reset();
        check("t5_err_clr", src_err, 0);

        // Asynchronous reset during beat 2 of a 4-beat burst
        req = 4'b0001; len = 16'h0003; rdy = 4'hF;
        tick();
        check("t6_gnt", gnt, 4'b0001);
        tick();
        tick();
        check("t6_beat2", rnd_valid, 1);
        reset = 1'b1;
        #1;
        check("t6_rst_gnt", gnt, 0);
        check("t6_rst_valid", rnd_valid, 0);
        check("t6_rst_data", rnd_data, 0);
        check("t6_rst_id", rnd_id, 0);
        check("t6_rst_last", rnd_last, 0);
        req = 4'hF;
        tick();
        reset = 1'b0;
        tick();
        check("t6_first_gnt", gnt, 4'b0001);
        tick();
        check("t6_first_beat_id", rnd_id, 0);
        check("t6_first_beat_valid", rnd_valid, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
